// File: rtl/instr_encoder_loader_if.sv
// Field-in / instruction-memory-write-out bundle for the instruction encoder-loader.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready handshake on the field side; the write side is a fire-and-forget strobe.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] base_addr;
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        opcode;
  logic [4:0]        rd2;
  logic [4:0]        rd1;
  logic [4:0]        rs2;
  logic [4:0]        rs1;
  logic [15:0]       imm;
  logic [7:0]        addr;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              err_illegal;
  logic              full;
  logic [ADDR_W:0]   count;

  // host / loader side
  modport master (
    output start, stop, base_addr, in_valid, opcode, rd2, rd1, rs2, rs1, imm, addr,
    input  in_ready, imem_we, imem_addr, imem_wdata, err_illegal, full, count
  );

  // encoder-loader side
  modport slave (
    input  start, stop, base_addr, in_valid, opcode, rd2, rd1, rs2, rs1, imm, addr,
    output in_ready, imem_we, imem_addr, imem_wdata, err_illegal, full, count
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs instruction fields into 32-bit words and writes them to sequential instruction-memory slots.
// Latency: handshake at edge N -> imem_we high in cycle N+1; one instruction per 2 cycles.
// Backpressure: in_ready low while writing, when full, outside a load, and whenever start is high.
module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_encoder_loader_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_FULL   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [31:0]       word_q, word_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              err_q, err_d;

  logic        legal;
  logic        hs;
  logic        in_ready;
  logic [31:0] enc;

  // Opcodes above the last ALU op (010000) have no encoding and are dropped.
  assign legal    = (bus.opcode <= 6'd16);
  assign in_ready = (state_q == S_ACCEPT) && !bus.start;
  assign hs       = bus.in_valid && in_ready;

  // Field packing; unused fields of an opcode never reach the word.
  always_comb begin
    enc        = '0;
    enc[31:26] = bus.opcode;
    case (bus.opcode)
      6'd0: begin
        enc[25:21] = bus.rd2;
        enc[15:0]  = bus.imm;
      end
      6'd1: begin
        enc[25:21] = bus.rd2;
        enc[4:0]   = bus.rs2;
      end
      6'd2: begin
        enc[25:21] = bus.rd2;
        enc[7:0]   = bus.addr;
      end
      6'd3: begin
        enc[25:18] = bus.addr;
        enc[4:0]   = bus.rs2;
      end
      default: begin
        enc[25:21] = bus.rd2;
        enc[20:16] = bus.rd1;
        enc[9:5]   = bus.rs2;
        enc[4:0]   = bus.rs1;
      end
    endcase
  end

  // Load sequencing: start always (re)opens a load; a write finishes before start takes effect.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    err_d   = 1'b0;
    case (state_q)
      S_ACCEPT: begin
        if (bus.start) begin
          pc_d    = bus.base_addr;
          cnt_d   = '0;
        end else if (hs) begin
          if (legal) begin
            word_d  = enc;
            waddr_d = pc_q;
            state_d = S_WRITE;
          end else begin
            err_d = 1'b1;
          end
        end else if (bus.stop) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        if (bus.start) begin
          pc_d    = bus.base_addr;
          cnt_d   = '0;
          state_d = S_ACCEPT;
        end else begin
          cnt_d = cnt_q + (ADDR_W+1)'(1);
          if (pc_q == {ADDR_W{1'b1}}) begin
            state_d = S_FULL;
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = S_ACCEPT;
          end
        end
      end
      default: begin  // S_IDLE and S_FULL both wait for start
        if (bus.start) begin
          pc_d    = bus.base_addr;
          cnt_d   = '0;
          state_d = S_ACCEPT;
        end
      end
    endcase
  end

  // State registers; reset kills any in-flight write immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      err_q   <= err_d;
    end
  end

  // Address/data come from dedicated registers so they hold after the strobe while pc moves on.
  assign bus.in_ready    = in_ready;
  assign bus.imem_we     = (state_q == S_WRITE);
  assign bus.imem_addr   = waddr_q;
  assign bus.imem_wdata  = word_q;
  assign bus.err_illegal = err_q;
  assign bus.full        = (state_q == S_FULL);
  assign bus.count       = cnt_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: an 8-bit-address instance and a 2-bit-address instance for the full boundary.
// Expected writes are queued when fields are driven and popped by per-instance write monitors.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_loader_if #(.ADDR_W(8)) if8 ();
  instr_encoder_loader_if #(.ADDR_W(2)) if2 ();

  instr_encoder_loader #(.ADDR_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  instr_encoder_loader #(.ADDR_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  // shared stimulus, routed to one instance by tgt (0 = 8-bit, 1 = 2-bit)
  logic        tgt = 1'b0;
  logic        start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [7:0]  base = '0;
  logic [5:0]  op = '0;
  logic [4:0]  f_rd2 = '0, f_rd1 = '0, f_rs2 = '0, f_rs1 = '0;
  logic [15:0] f_imm = '0;
  logic [7:0]  f_addr = '0;
  logic        rdy;

  assign if8.start     = start & ~tgt;
  assign if2.start     = start & tgt;
  assign if8.stop      = stop & ~tgt;
  assign if2.stop      = stop & tgt;
  assign if8.in_valid  = in_valid & ~tgt;
  assign if2.in_valid  = in_valid & tgt;
  assign if8.base_addr = base;
  assign if2.base_addr = base[1:0];
  assign if8.opcode = op;     assign if2.opcode = op;
  assign if8.rd2 = f_rd2;     assign if2.rd2 = f_rd2;
  assign if8.rd1 = f_rd1;     assign if2.rd1 = f_rd1;
  assign if8.rs2 = f_rs2;     assign if2.rs2 = f_rs2;
  assign if8.rs1 = f_rs1;     assign if2.rs1 = f_rs1;
  assign if8.imm = f_imm;     assign if2.imm = f_imm;
  assign if8.addr = f_addr;   assign if2.addr = f_addr;
  assign rdy = tgt ? if2.in_ready : if8.in_ready;

  int tests = 0;
  int fails = 0;
  logic [39:0] sb[$];       // {write address, encoded word}
  logic [7:0]  pc_m = '0;   // model of the next write address
  logic [39:0] e8, e2;
  logic        prev_we8 = 1'b0, prev_we2 = 1'b0;

  function automatic logic [31:0] model_enc(input logic [5:0] o, input logic [4:0] r2, r1, s2, s1,
                                            input logic [15:0] im, input logic [7:0] ad);
    logic [31:0] w;
    w = {o, 26'd0};
    if (o == 6'd0)      w = w | (32'(r2) << 21) | 32'(im);
    else if (o == 6'd1) w = w | (32'(r2) << 21) | 32'(s2);
    else if (o == 6'd2) w = w | (32'(r2) << 21) | 32'(ad);
    else if (o == 6'd3) w = w | (32'(ad) << 18) | 32'(s2);
    else                w = w | (32'(r2) << 21) | (32'(r1) << 16) | (32'(s2) << 5) | 32'(s1);
    return w;
  endfunction

  // write monitor, 8-bit instance
  always @(negedge clk) begin
    if (if8.imem_we) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL write8_unexpected addr=%h data=%h", if8.imem_addr, if8.imem_wdata);
      end else begin
        e8 = sb.pop_front();
        if ({if8.imem_addr, if8.imem_wdata} !== e8) begin
          fails++;
          $display("FAIL write8 got addr=%h data=%h exp addr=%h data=%h",
                   if8.imem_addr, if8.imem_wdata, e8[39:32], e8[31:0]);
        end
      end
      tests++;
      if (if8.in_ready !== 1'b0) begin
        fails++; $display("FAIL ready8_in_write got=%b exp=0", if8.in_ready);
      end
      tests++;
      if (prev_we8 !== 1'b0) begin
        fails++; $display("FAIL we8_width got=two-cycle exp=one-cycle");
      end
    end
    prev_we8 = if8.imem_we;
  end

  // write monitor, 2-bit instance
  always @(negedge clk) begin
    if (if2.imem_we) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL write2_unexpected addr=%h data=%h", if2.imem_addr, if2.imem_wdata);
      end else begin
        e2 = sb.pop_front();
        if ({6'd0, if2.imem_addr, if2.imem_wdata} !== e2) begin
          fails++;
          $display("FAIL write2 got addr=%h data=%h exp addr=%h data=%h",
                   if2.imem_addr, if2.imem_wdata, e2[39:32], e2[31:0]);
        end
      end
      tests++;
      if (prev_we2 !== 1'b0) begin
        fails++; $display("FAIL we2_width got=two-cycle exp=one-cycle");
      end
    end
    prev_we2 = if2.imem_we;
  end

  task automatic pulse_start(input logic t, input logic [7:0] b);
    tgt = t; base = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pc_m = b;
  endtask

  // Present one field set and wait (bounded) for the handshake edge; returns 1ns after it.
  task automatic send(input logic [5:0] o, input logic [4:0] r2, r1, s2, s1, input logic [15:0] im,
                      input logic [7:0] ad, input logic [31:0] exp, input bit hold);
    bit got;
    bit pushed;
    op = o; f_rd2 = r2; f_rd1 = r1; f_rs2 = s2; f_rs1 = s1; f_imm = im; f_addr = ad;
    in_valid = 1'b1;
    pushed = 1'b0;
    if (o <= 6'd16) begin
      sb.push_back({pc_m, exp});
      pc_m = pc_m + 8'd1;
      pushed = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin got = 1'b1; break; end
    end
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL handshake_timeout op=%h got=no-ready exp=ready", o);
      if (pushed) void'(sb.pop_back());
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({if8.in_ready, if8.imem_we, if8.imem_addr, if8.imem_wdata, if8.err_illegal, if8.full, if8.count} !== '0) begin
      fails++;
      $display("FAIL reset8 got we=%b rdy=%b addr=%h data=%h err=%b full=%b cnt=%0d exp=all-zero",
               if8.imem_we, if8.in_ready, if8.imem_addr, if8.imem_wdata, if8.err_illegal, if8.full, if8.count);
    end
    tests++;
    if ({if2.in_ready, if2.imem_we, if2.full, if2.count} !== '0) begin
      fails++; $display("FAIL reset2 got=nonzero exp=all-zero");
    end
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (if8.in_ready !== 1'b0) begin
      fails++; $display("FAIL idle_ready got=%b exp=0", if8.in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_ldi;
    pulse_start(1'b0, 8'h00);
    tests++;
    if (if8.count !== 9'd0) begin
      fails++; $display("FAIL start_count got=%0d exp=0", if8.count);
    end
    send(6'd0, 5'd3, 5'd0, 5'd0, 5'd0, 16'h1234, 8'h00, 32'h00601234, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (if8.count !== 9'd1) begin
      fails++; $display("FAIL ldi_count got=%0d exp=1", if8.count);
    end
  endtask

  task automatic test_back_to_back;
    send(6'd4, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 8'h00, 32'h10220064, 1'b1);
    send(6'd1, 5'd7, 5'd9, 5'd12, 5'd0, 16'hBEEF, 8'h55,
         model_enc(6'd1, 5'd7, 5'd9, 5'd12, 5'd0, 16'hBEEF, 8'h55), 1'b0);
    @(posedge clk); #1;
    tests++;
    if (if8.count !== 9'd3) begin
      fails++; $display("FAIL b2b_count got=%0d exp=3", if8.count);
    end
    tests++;
    if (if8.imem_addr !== 8'd2) begin
      fails++; $display("FAIL addr_hold got=%h exp=02", if8.imem_addr);
    end
  endtask

  task automatic test_store;
    send(6'd3, 5'h1F, 5'h1A, 5'd5, 5'h11, 16'hFFFF, 8'hAB, 32'h0EAC0005, 1'b0);
    send(6'd2, 5'd30, 5'h0F, 5'h0F, 5'h0F, 16'hAAAA, 8'h7E,
         model_enc(6'd2, 5'd30, 5'h0F, 5'h0F, 5'h0F, 16'hAAAA, 8'h7E), 1'b0);
    send(6'd16, 5'd31, 5'd17, 5'd8, 5'd1, 16'h0, 8'h00,
         model_enc(6'd16, 5'd31, 5'd17, 5'd8, 5'd1, 16'h0, 8'h00), 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_illegal;
    logic [8:0] c;
    c = if8.count;
    send(6'h11, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 8'h1, 32'h0, 1'b0);
    @(negedge clk);
    tests++;
    if (if8.err_illegal !== 1'b1) begin
      fails++; $display("FAIL err_pulse got=%b exp=1", if8.err_illegal);
    end
    @(negedge clk);
    tests++;
    if (if8.err_illegal !== 1'b0) begin
      fails++; $display("FAIL err_width got=%b exp=0", if8.err_illegal);
    end
    tests++;
    if (if8.count !== c) begin
      fails++; $display("FAIL illegal_count got=%0d exp=%0d", if8.count, c);
    end
    @(posedge clk); #1;
    send(6'h0A, 5'd2, 5'd3, 5'd4, 5'd5, 16'h0, 8'h00,
         model_enc(6'h0A, 5'd2, 5'd3, 5'd4, 5'd5, 16'h0, 8'h00), 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_stop;
    stop = 1'b1;
    send(6'h0E, 5'd6, 5'd7, 5'd8, 5'd9, 16'h0, 8'h00,
         model_enc(6'h0E, 5'd6, 5'd7, 5'd8, 5'd9, 16'h0, 8'h00), 1'b0);
    stop = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (if8.in_ready !== 1'b1) begin
      fails++; $display("FAIL stop_vs_hs got ready=%b exp=1", if8.in_ready);
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (if8.in_ready !== 1'b0) begin
      fails++; $display("FAIL stop_idle got ready=%b exp=0", if8.in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_start_masks;
    pulse_start(1'b0, 8'h10);
    send(6'd5, 5'd1, 5'd1, 5'd2, 5'd2, 16'h0, 8'h00,
         model_enc(6'd5, 5'd1, 5'd1, 5'd2, 5'd2, 16'h0, 8'h00), 1'b0);
    pulse_start(1'b0, 8'h40);   // lands on the edge ending the write
    tests++;
    if (if8.count !== 9'd0) begin
      fails++; $display("FAIL start_in_write_count got=%0d exp=0", if8.count);
    end
    op = 6'd4; in_valid = 1'b1; start = 1'b1; base = 8'h20;
    @(negedge clk);
    tests++;
    if (if8.in_ready !== 1'b0) begin
      fails++; $display("FAIL start_masks_ready got=%b exp=0", if8.in_ready);
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; pc_m = 8'h20;
    send(6'h0F, 5'd4, 5'd5, 5'd6, 5'd7, 16'h0, 8'h00,
         model_enc(6'h0F, 5'd4, 5'd5, 5'd6, 5'd7, 16'h0, 8'h00), 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_full;
    pulse_start(1'b1, 8'h02);
    send(6'd0, 5'd1, 5'd0, 5'd0, 5'd0, 16'hCAFE, 8'h00,
         model_enc(6'd0, 5'd1, 5'd0, 5'd0, 5'd0, 16'hCAFE, 8'h00), 1'b0);
    send(6'd7, 5'd2, 5'd3, 5'd4, 5'd5, 16'h0, 8'h00,
         model_enc(6'd7, 5'd2, 5'd3, 5'd4, 5'd5, 16'h0, 8'h00), 1'b1);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (if2.full !== 1'b1) begin
      fails++; $display("FAIL full_flag got=%b exp=1", if2.full);
    end
    tests++;
    if (if2.in_ready !== 1'b0) begin
      fails++; $display("FAIL full_ready got=%b exp=0", if2.in_ready);
    end
    tests++;
    if (if2.count !== 3'd2) begin
      fails++; $display("FAIL full_count got=%0d exp=2", if2.count);
    end
    in_valid = 1'b0;
    pulse_start(1'b1, 8'h00);
    tests++;
    if ({if2.full, if2.count} !== 4'd0) begin
      fails++; $display("FAIL restart got full=%b cnt=%0d exp full=0 cnt=0", if2.full, if2.count);
    end
    send(6'd1, 5'd9, 5'd0, 5'd3, 5'd0, 16'h0, 8'h00,
         model_enc(6'd1, 5'd9, 5'd0, 5'd3, 5'd0, 16'h0, 8'h00), 1'b0);
    @(posedge clk); #1;
    tgt = 1'b0;
  endtask

  task automatic test_rst_mid_write;
    pulse_start(1'b0, 8'h80);
    send(6'd8, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 8'h00,
         model_enc(6'd8, 5'd1, 5'd2, 5'd3, 5'd4, 16'h0, 8'h00), 1'b0);
    tests++;
    if (if8.imem_we !== 1'b1) begin
      fails++; $display("FAIL pre_rst_we got=%b exp=1", if8.imem_we);
    end
    #1 rst = 1'b1;
    #1;
    void'(sb.pop_back());   // that write is lost
    tests++;
    if ({if8.imem_we, if8.in_ready, if8.imem_addr, if8.imem_wdata, if8.err_illegal, if8.full, if8.count} !== '0) begin
      fails++;
      $display("FAIL rst_async got we=%b addr=%h data=%h cnt=%0d exp=all-zero",
               if8.imem_we, if8.imem_addr, if8.imem_wdata, if8.count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (if8.in_ready !== 1'b0) begin
      fails++; $display("FAIL post_rst_ready got=%b exp=0", if8.in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pulse_start(1'b0, 8'h00);
    send(6'd6, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0, 8'h00,
         model_enc(6'd6, 5'd3, 5'd0, 5'd0, 5'd0, 16'h0, 8'h00), 1'b0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_back_to_back();
    test_store();
    test_illegal();
    test_stop();
    test_start_masks();
    test_full();
    test_rst_mid_write();
    repeat (3) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Instruction encoder and program loader for the 16-bit Harvard processor. Takes one instruction at a time as separate fields (opcode, register numbers, immediate, data address) over a valid/ready handshake. Packs them into the 32-bit instruction word format that the decode stage splits apart, then writes the word into instruction memory at sequential addresses. It sits between the host/test loader and the instruction-memory write port. It is the write-side counterpart of the decode stage.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W words

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  pulse; begin a load at base_addr (valid in any state)
- stop  in  1  pulse; end load, return to IDLE (ignored outside ACCEPT)
- base_addr  in  ADDR_W  first write address, sampled with start
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block accepts fields this cycle
- opcode  in  6  instruction opcode
- rd2, rd1, rs2, rs1  in  5 each  register fields
- imm  in  16  immediate (LDI)
- addr  in  8  data-memory address (LOAD/STORE)
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction word
- err_illegal  out  1  one-cycle pulse, illegal opcode dropped
- full  out  1  last memory slot written; load halted
- count  out  ADDR_W+1  instructions written since last start

## Operation
- Encoding; all bits not listed are 0; opcode always goes in [31:26]:
  - 000000 LDI: [25:21]=rd2, [15:0]=imm
  - 000001 MOV: [25:21]=rd2, [4:0]=rs2
  - 000010 LOAD: [25:21]=rd2, [7:0]=addr
  - 000011 STORE: [25:18]=addr, [4:0]=rs2
  - 000100..010000 (ALU ops: add, sub, neg, mul, and, or, xor, nand, nor, xnor, not, shl, shr): [25:21]=rd2, [20:16]=rd1, [9:5]=rs2, [4:0]=rs1, [15:10]=0
  - opcode > 010000: illegal
- Field inputs not used by an opcode are ignored; they are not checked.
- FSM states:
  - IDLE: on start, pc<=base_addr, count<=0, go to ACCEPT.
  - ACCEPT: in_ready=1 unless start is high. On handshake (in_valid & in_ready):
    - Legal opcode: latch the encoded word, go to WRITE.
    - Illegal opcode: err_illegal=1 next cycle, stay in ACCEPT, pc and count unchanged.
    - stop (with no handshake in the same cycle): go to IDLE.
  - WRITE: imem_we=1, imem_addr=pc, imem_wdata=latched word. Next edge: count+1. If pc==2**ADDR_W-1, go to FULL (pc held); else pc+1, go to ACCEPT.
  - FULL: full=1, in_ready=0. start restarts the load as in IDLE.
- start in ACCEPT or FULL reloads pc and clears count. In ACCEPT it masks in_ready, so no field set is accepted that cycle.
- stop and handshake in the same cycle: the handshake wins and stop is ignored.
- start during WRITE: the write completes this cycle, then pc<=base_addr, count<=0, state ACCEPT.
- No wrap: the block never writes past the top address.

## Timing
- Reset values: all outputs 0, state IDLE, pc 0, count 0, latched word 0.
- Latency: handshake at edge N; imem_we high in cycle N+1 (registered outputs).
- Throughput: one instruction per 2 cycles.
- err_illegal: high for exactly the one cycle after the offending handshake.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- rst asserted mid-WRITE: imem_we drops immediately (asynchronous), state IDLE, and the write is lost.

## Test plan
- Reset, start base_addr=0, LDI rd2=3 imm=0x1234 -> one cycle of imem_we, addr 0, wdata 0x00601234; count=1.
- ADD (000100) rd2=1 rd1=2 rs2=3 rs1=4, back-to-back with in_valid held high -> wdata 0x10220064 at addr 1; in_ready low during WRITE.
- STORE addr=0xAB rs2=5, with rd1/imm driven to junk values -> wdata 0x0EAC0005.
- Opcode 010001 -> err_illegal one-cycle pulse, no imem_we, pc/count unchanged; next legal instruction written at the unchanged pc.
- ADDR_W=2, base_addr=2, two legal instructions -> writes at addr 2 and 3, then full=1, in_ready=0, count=2; start base_addr=0 clears full and the next write goes to addr 0.
- rst pulse while imem_we=1 -> imem_we=0 in the same cycle, all outputs 0, in_ready stays 0 until start.
